// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: ROM byte port, redirect request and the instruction handshake.
// master = fetch unit side, slave = ROM / control-unit side.
interface instruction_fetch_unit_if;
    logic        fetch_en;
    logic [15:0] addr_bus_out;
    logic [7:0]  data_bus_in;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [1:0]  instr_length;
    logic [15:0] instr_pc;

    modport master (
        input  fetch_en, data_bus_in, redirect_valid, redirect_pc, instr_ready,
        output addr_bus_out, instr_valid, instr_opcode, instr_operand, instr_length, instr_pc
    );

    modport slave (
        output fetch_en, data_bus_in, redirect_valid, redirect_pc, instr_ready,
        input  addr_bus_out, instr_valid, instr_opcode, instr_operand, instr_length, instr_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// 65C02 byte-serial fetch stage: assembles opcode + operands and queues whole instructions.
// Define IFU_PERF_COUNTERS_EN to add the perf_instr_count / perf_stall_count outputs.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter int          QUEUE_DEPTH  = 2
) (
    input  logic clk_in,
    input  logic reset,
    instruction_fetch_unit_if.master bus
`ifdef IFU_PERF_COUNTERS_EN
    ,
    output logic [15:0] perf_instr_count,
    output logic [15:0] perf_stall_count
`endif
);
    localparam logic [1:0] FETCH_OP  = 2'd0;
    localparam logic [1:0] FETCH_LO  = 2'd1;
    localparam logic [1:0] FETCH_HI  = 2'd2;
    localparam logic [2:0] DEPTH     = 3'(QUEUE_DEPTH);
    localparam logic [1:0] LAST_SLOT = 2'(QUEUE_DEPTH - 1);

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] operand;
        logic [1:0]  length;
        logic [15:0] pc;
    } entry_t;

    logic [1:0]  state;
    logic [15:0] fetch_pc;
    logic [7:0]  op_p0;
    logic [15:0] pc_p0;
    logic [1:0]  len_p0;
    logic [7:0]  lo_p0;
    entry_t      q_mem [4];
    entry_t      head;
    entry_t      push_entry;
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  count;
    logic        consume, push, pop;
    logic [1:0]  byte_len;

    function automatic logic [1:0] op_length(input logic [7:0] op);
        case (op[3:0])
            4'h0: begin
                if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 2'd1;
                else if (op == 8'h20)                          return 2'd3;
                else                                           return 2'd2;
            end
            4'h3, 4'h8, 4'hA, 4'hB: return 2'd1;
            4'h9:                   return op[4] ? 2'd3 : 2'd2;
            4'hC, 4'hD, 4'hE, 4'hF: return 2'd3;
            default:                return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] next_slot(input logic [1:0] p);
        return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
    endfunction

    assign byte_len = op_length(bus.data_bus_in);

    // Byte consume / push decision: an opcode fetch only starts with queue space free,
    // so operand bytes never need to check occupancy.
    always_comb begin
        consume    = bus.fetch_en && !bus.redirect_valid && (state != FETCH_OP || count < DEPTH);
        pop        = (count != 3'd0) && bus.instr_ready;
        push       = 1'b0;
        push_entry = '{opcode: op_p0, operand: 16'h0000, length: len_p0, pc: pc_p0};
        if (consume) begin
            case (state)
                FETCH_OP: if (byte_len == 2'd1) begin
                    push       = 1'b1;
                    push_entry = '{opcode: bus.data_bus_in, operand: 16'h0000, length: 2'd1, pc: fetch_pc};
                end
                FETCH_LO: if (len_p0 == 2'd2) begin
                    push               = 1'b1;
                    push_entry.operand = {8'h00, bus.data_bus_in};
                end
                FETCH_HI: begin
                    push               = 1'b1;
                    push_entry.operand = {bus.data_bus_in, lo_p0};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= FETCH_OP;
            fetch_pc <= RESET_VECTOR;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 3'd0;
        end else if (bus.redirect_valid) begin
            state    <= FETCH_OP;
            fetch_pc <= bus.redirect_pc;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 3'd0;
        end else begin
            if (consume) begin
                fetch_pc <= fetch_pc + 16'd1;
                case (state)
                    FETCH_OP: state <= (byte_len == 2'd1) ? FETCH_OP : FETCH_LO;
                    FETCH_LO: state <= (len_p0 == 2'd3) ? FETCH_HI : FETCH_OP;
                    default:  state <= FETCH_OP;
                endcase
            end
            if (push) wr_ptr <= next_slot(wr_ptr);
            if (pop)  rd_ptr <= next_slot(rd_ptr);
            count <= count + 3'(push) - 3'(pop);
        end
    end

    // Staging and queue storage carry no reset; occupancy gates their visibility.
    always_ff @(posedge clk_in) begin
        if (consume) begin
            case (state)
                FETCH_OP: begin
                    op_p0  <= bus.data_bus_in;
                    pc_p0  <= fetch_pc;
                    len_p0 <= byte_len;
                end
                FETCH_LO: lo_p0 <= bus.data_bus_in;
                default: ;
            endcase
        end
        if (push) q_mem[wr_ptr] <= push_entry;
    end

    assign head              = q_mem[rd_ptr];
    assign bus.addr_bus_out  = fetch_pc;
    assign bus.instr_valid   = (count != 3'd0);
    assign bus.instr_opcode  = bus.instr_valid ? head.opcode  : 8'h00;
    assign bus.instr_operand = bus.instr_valid ? head.operand : 16'h0000;
    assign bus.instr_length  = bus.instr_valid ? head.length  : 2'd0;
    assign bus.instr_pc      = bus.instr_valid ? head.pc      : 16'h0000;

`ifdef IFU_PERF_COUNTERS_EN
    always_ff @(posedge clk_in) begin
        if (reset || bus.redirect_valid) begin
            perf_instr_count <= 16'h0000;
            perf_stall_count <= 16'h0000;
        end else begin
            if (pop) perf_instr_count <= perf_instr_count + 16'd1;
            if (state == FETCH_OP && bus.fetch_en && count == DEPTH)
                perf_stall_count <= perf_stall_count + 16'd1;
        end
    end
`endif
endmodule
